// File: rtl/mdu_param.sv
// Parameterised multiply/divide unit with architectural HI/LO registers.
// Arithmetic ops run for a fixed latency; results land in HI/LO on completion.
module mdu_param #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);
  localparam int unsigned DW      = 2 * WIDTH;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a, b;
  logic [3:0]       pend_op;

  logic [DW-1:0]    sprod, uprod, hilo;
  logic [WIDTH-1:0] abs_a, abs_b, q_mag, r_mag, div_q, div_r;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             div_signed;

  // Completion value from the latched operands; the signed-overflow case
  // falls out of the magnitude divide (|min|/1 negated back to min, rem 0).
  always_comb begin
    res_hi     = '0;
    res_lo     = '0;
    q_mag      = '0;
    r_mag      = '0;
    hilo       = {hi, lo};
    sprod      = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    uprod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    div_signed = (pend_op == OP_DIV);
    abs_a      = (div_signed && a[WIDTH-1]) ? -a : a;
    abs_b      = (div_signed && b[WIDTH-1]) ? -b : b;
    if (b != '0) begin
      q_mag = abs_a / abs_b;
      r_mag = abs_a % abs_b;
    end
    div_q = (div_signed && (a[WIDTH-1] ^ b[WIDTH-1])) ? -q_mag : q_mag;
    div_r = (div_signed && a[WIDTH-1]) ? -r_mag : r_mag;
    if (b == '0) begin
      div_q = '1;
      div_r = a;
    end
    case (pend_op)
      OP_MULT:  {res_hi, res_lo} = sprod;
      OP_MULTU: {res_hi, res_lo} = uprod;
      OP_MADD:  {res_hi, res_lo} = hilo + sprod;
      OP_MSUB:  {res_hi, res_lo} = hilo - sprod;
      default:  {res_hi, res_lo} = {div_r, div_q};
    endcase
  end

  assign result = (op == OP_MFLO) ? lo : hi;

  // Control FSM, operand latch and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      a       <= '0;
      b       <= '0;
      pend_op <= OP_NOP;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            case (op)
              OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                a       <= d1;
                b       <= d2;
                pend_op <= op;
                cnt     <= CW'(MUL_LAT);
                state   <= RUN;
                busy    <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                a       <= d1;
                b       <= d2;
                pend_op <= op;
                cnt     <= CW'(DIV_LAT);
                state   <= RUN;
                busy    <= 1'b1;
              end
              OP_MTHI: hi <= d1;
              OP_MTLO: lo <= d1;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_param.sv
// Self-checking bench for mdu_param: directed scenarios plus random ops
// compared against a 64-bit integer reference model of HI/LO.
module tb_mdu_param;

  logic        clk = 1'b0;
  logic        reset, start, cancel, busy;
  logic [3:0]  op;
  logic [31:0] d1, d2, result, hi, lo;

  logic        s_start, s_cancel, s_busy;
  logic [3:0]  s_op;
  logic [15:0] s_d1, s_d2, s_result, s_hi, s_lo;

  logic [31:0] m_hi, m_lo;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mdu_param dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
    .cancel(cancel), .busy(busy), .result(result), .hi(hi), .lo(lo)
  );

  mdu_param #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .d1(s_d1), .d2(s_d2),
    .cancel(s_cancel), .busy(s_busy), .result(s_result), .hi(s_hi), .lo(s_lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: HI/LO as one 64-bit value, results from plain integer arithmetic.
  function automatic void ref_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = 64'(a);
    ub  = 64'(b);
    acc = {m_hi, m_lo};
    case (o)
      4'd1: acc = 64'(sa * sb);
      4'd2: acc = ua * ub;
      4'd3: if (b == 0) acc = {a, 32'hFFFF_FFFF};
            else begin q = sa / sb; r = sa % sb; acc = {r[31:0], q[31:0]}; end
      4'd4: if (b == 0) acc = {a, 32'hFFFF_FFFF};
            else acc = {32'(ua % ub), 32'(ua / ub)};
      4'd5: acc[63:32] = a;
      4'd6: acc[31:0]  = a;
      4'd9:  acc = acc + 64'(sa * sb);
      4'd10: acc = acc - 64'(sa * sb);
      default: ;
    endcase
    {m_hi, m_lo} = acc;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; inj = busy cycle in which a stray start is driven,
  // cxl = busy cycle in which cancel is driven (0 = none).
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input logic [3:0] inj_op, input int cxl);
    int n, lat, exp_n;
    bit arith, killed;
    arith = (o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10});
    lat   = (o == 4'd3 || o == 4'd4) ? 10 : 5;
    op = o; d1 = a; d2 = b; start = 1'b1;
    #1;
    check("result_mux", result, (o == 4'd8) ? m_lo : m_hi);
    tick();
    start = 1'b0; op = 4'd0; d1 = $urandom; d2 = $urandom;
    if (!arith) begin
      ref_apply(o, a, b);
      check("idle_busy", busy, 1'b0);
      check("imm_hi", hi, m_hi);
      check("imm_lo", lo, m_lo);
      return;
    end
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 1) check("hold_hilo", {hi, lo}, {m_hi, m_lo});
      if (n == inj) begin start = 1'b1; op = inj_op; d1 = $urandom; d2 = $urandom; end
      if (n == cxl) cancel = 1'b1;
      tick();
      start = 1'b0; cancel = 1'b0; op = 4'd0;
    end
    killed = (cxl > 0 && cxl <= lat);
    exp_n  = killed ? cxl : lat;
    check("busy_len", 64'(n), 64'(exp_n));
    if (!killed) ref_apply(o, a, b);
    check("done_hi", hi, m_hi);
    check("done_lo", lo, m_lo);
  endtask

  task automatic run_small(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                           input int exp_lat, input logic [15:0] exp_hi, input logic [15:0] exp_lo);
    int n;
    s_op = o; s_d1 = a; s_d2 = b; s_start = 1'b1;
    tick();
    s_start = 1'b0; s_op = 4'd0;
    n = 0;
    while (s_busy && n < 20) begin
      n++;
      tick();
    end
    check("s_busy_len", 64'(n), 64'(exp_lat));
    check("s_hi", s_hi, exp_hi);
    check("s_lo", s_lo, exp_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_rst;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 4'd0; d1 = '0; d2 = '0;
    s_start = 1'b0; s_cancel = 1'b0; s_op = 4'd0; s_d1 = '0; s_d2 = '0;
    m_hi = '0; m_lo = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_s_busy", s_busy, 1'b0);

    // MULT and read back through the C-select mux
    run_op(4'd1, -32'd3, 32'd7, 0, 4'd0, 0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    op = 4'd8; #1;
    check("mflo_result", result, 32'hFFFF_FFEB);
    op = 4'd0;

    // Signed divide, divide by zero, overflow
    run_op(4'd3, -32'd7, 32'd2, 0, 4'd0, 0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    run_op(4'd4, 32'd5, 32'd0, 0, 4'd0, 0);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'd5);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 4'd0, 0);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);

    // MTHI/MTLO then accumulate/subtract
    run_op(4'd5, 32'd0, 32'd0, 0, 4'd0, 0);
    run_op(4'd6, 32'd10, 32'd0, 0, 4'd0, 0);
    run_op(4'd9, 32'd4, 32'd5, 0, 4'd0, 0);
    check("madd_lo", lo, 32'd30);
    check("madd_hi", hi, 32'd0);
    run_op(4'd10, 32'd4, 32'd8, 0, 4'd0, 0);
    check("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

    // Ignored start while busy, cancel mid-run, cancel at completion
    run_op(4'd2, 32'd123, 32'd456, 2, 4'd2, 0);
    run_op(4'd3, 32'd1000, 32'd7, 0, 4'd0, 3);
    run_op(4'd1, 32'd99, 32'd99, 0, 4'd0, 5);
    op = 4'd6; d1 = 32'd9; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0; op = 4'd0;
    check("cxl_mtlo_lo", lo, m_lo);
    check("cxl_mtlo_busy", busy, 1'b0);

    // Reset during the 4th busy cycle of a MULT
    op = 4'd1; d1 = 32'd11; d2 = 32'd13; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    cnt_rst = 1;
    while (cnt_rst < 4) begin cnt_rst++; tick(); end
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_hilo", {hi, lo}, 64'h0);
    run_op(4'd1, 32'd6, 32'd7, 0, 4'd0, 0);

    // Narrow configuration
    run_small(4'd2, 16'hFFFF, 16'hFFFF, 1, 16'hFFFE, 16'h0001);
    run_small(4'd3, -16'd7, 16'd2, 3, 16'hFFFF, 16'hFFFD);
    run_small(4'd3, 16'h8000, 16'hFFFF, 3, 16'h0000, 16'h8000);

    // Random ops against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [3:0] ro;
      int rlat, rcxl, rinj;
      ro   = 4'($urandom_range(0, 15));
      rlat = (ro == 4'd3 || ro == 4'd4) ? 10 : 5;
      rcxl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, rlat) : 0;
      rinj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rlat) : 0;
      run_op(ro, pick(), pick(), rinj, 4'($urandom_range(1, 10)), rcxl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_param.md
# mdu_param

Parameterised multiply/divide unit for the execute stage. It is the successor to the fixed 32-bit MDU, with configurable data width and per-class latency, multiply-accumulate/subtract, defined divide-by-zero results, and an exception-flush cancel. It sits beside the ALU in stage E. It holds the architectural HI/LO registers, raises `busy` while an operation is in flight, and returns HI or LO through `result` for the C-select mux.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be at least 2.
- `MUL_LAT`, default 5: busy cycles for MULT/MULTU/MADD/MSUB; must be at least 1.
- `DIV_LAT`, default 10: busy cycles for DIV/DIVU; must be at least 1.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  qualifies `op` for one cycle.
- `op`  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MSUB; 11–15 behave as NOP.
- `d1`  in  WIDTH  forwarded rs operand.
- `d2`  in  WIDTH  forwarded rt operand.
- `cancel`  in  1  exception flush; aborts the in-flight operation and suppresses `start`.
- `busy`  out  1  operation in flight; the pipeline stalls any MDU instruction in E while high.
- `result`  out  WIDTH  combinational: `lo` when `op`=8, otherwise `hi`.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- **States**
  - IDLE and RUN. A down-counter `cnt` of ceil(log2(max(MUL_LAT,DIV_LAT)+1)) bits tracks RUN.
  - Latched state: operands `a`, `b`, and the pending op.
- **Accept**
  - A command is accepted when `start`=1, `busy`=0 and `cancel`=0.
  - `start` while `busy`=1 is ignored; no queueing.
- **Arithmetic ops (1–4, 9, 10)**
  - On accept: latch `d1`/`d2`/`op`, load `cnt`=MUL_LAT or DIV_LAT, go to RUN.
  - In RUN, `cnt` decrements each cycle. At the edge where `cnt` goes 1→0, HI/LO are written and the state returns to IDLE.
- **MTHI / MTLO**
  - On accept, `hi`/`lo` takes `d1` at that edge; `busy` is not raised.
- **MFHI / MFLO / NOP**
  - No state change.
- **Multiply results**
  - MULT: {hi,lo} = signed a × signed b, 2·WIDTH bits.
  - MULTU: the same product, unsigned.
  - MADD: {hi,lo} += signed product.
  - MSUB: {hi,lo} −= signed product.
  - MADD/MSUB use the HI/LO values at completion time, modulo 2^(2·WIDTH).
- **Divide results**
  - DIV is signed: `lo` = quotient truncated toward zero; `hi` = remainder, with the sign of the dividend.
  - DIVU is unsigned.
  - Divide by zero (either op): `lo` = all ones, `hi` = a.
  - Signed overflow (a = −2^(WIDTH−1), b = −1): `lo` = a, `hi` = 0.
- **Implementation freedom**
  - Any internal algorithm is allowed, provided the results appear exactly at the specified latency.

## Timing
- **Reset**
  - Takes effect at the next edge and overrides everything, including mid-operation.
  - After reset: `hi`=0, `lo`=0, `busy`=0, `cnt`=0, state IDLE.
- **Busy window**
  - An accept at edge N puts `busy`=1 from after edge N through the cycle before edge N+LAT.
  - New HI/LO are visible and `busy`=0 after edge N+LAT.
  - `busy` is registered: `(state==RUN)`.
- **Back-to-back**
  - A new `start` is accepted in the first cycle with `busy`=0, i.e. at edge N+LAT+1 or later.
- **Cancel**
  - `cancel`=1 while RUN: back to IDLE at that edge, `busy`=0 after it, HI/LO unchanged.
  - `cancel`=1 on the edge where `cnt` would hit 0: the result is discarded.
  - `cancel` with `start` in IDLE: nothing is accepted, including MTHI/MTLO.
- **Reads during RUN**
  - `hi`/`lo` and `result` keep their pre-operation values until completion.

## Test plan
- **Reset and MULT** (defaults): assert `reset` 2 cycles → `hi`=`lo`=0, `busy`=0. Then MULT d1=−3, d2=7 → `busy` high exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; MFLO gives `result`=0xFFFFFFEB.
- **DIV and divide-by-zero:** DIV −7/2 → after 10 busy cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 5/0 → `lo`=0xFFFFFFFF, `hi`=5.
- **Overflow and MADD:** DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0. Then MTHI 0, MTLO 10, MADD 4×5 → `lo`=30, `hi`=0. MSUB 4×8 → `hi`:`lo` = 0xFFFFFFFF:0xFFFFFFFE.
- **Ignored start and cancel:** start MULTU while busy → ignored, latency unchanged. Cancel in the 3rd busy cycle of a DIV → `busy` drops next cycle, HI/LO hold old values. Cancel coincident with MTLO 9 → `lo` unchanged.
- **Reset mid-operation:** reset asserted during cycle 4 of a MULT → `busy`=0, `hi`=`lo`=0 after that edge; a new start is accepted the next cycle.
- **Parameter sweep:** WIDTH=16, MUL_LAT=1, DIV_LAT=3 → MULTU 0xFFFF×0xFFFF gives `hi`=0xFFFE, `lo`=0x0001 with 1 busy cycle. Random ops are checked against a reference model at every completion.
